// File: rtl/ext_finish_pkg.sv
// ============================================================================
// Module      : ext_finish_pkg
// Description : Shared types and constants for the exit/finish request block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ext_finish_pkg;

  localparam int          FINISH_ARG_W      = 9;
  localparam int          EXITCODE_W        = 8;
  localparam int          GRACE_W           = 16;
  localparam logic [31:0] EXIT_ADDR_DEFAULT = 32'h4000_1000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FIRE  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [FINISH_ARG_W-1:0] pack_finish(
    input logic                  finish,
    input logic [EXITCODE_W-1:0] code
  );
    return {finish, code};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ext_finish_grace_ctr.sv
// ============================================================================
// Module      : ext_finish_grace_ctr
// Description : Loadable down-counter that stops at 1 and flags that value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ext_finish_grace_ctr
  import ext_finish_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               load,
  input  logic [GRACE_W-1:0] load_val,
  input  logic               dec,
  output logic               at_one
);

  localparam logic [GRACE_W-1:0] c_one = GRACE_W'(1);

  logic [GRACE_W-1:0] r_count;

  // Decrement saturates at 1 so the counter can never wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count > c_one)) begin
      r_count <= r_count - c_one;
    end
  end

  assign at_one = (r_count == c_one);

endmodule

`default_nettype wire

// File: rtl/ext_finish_req.sv
// ============================================================================
// Module      : ext_finish_req
// Description : Latches an exit code from an MMIO store and, once the console
//               has drained and a grace interval has passed, pulses finish.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ext_finish_req
  import ext_finish_pkg::*;
#(
  parameter logic [31:0] EXIT_ADDR    = EXIT_ADDR_DEFAULT,
  parameter int unsigned GRACE_CYCLES = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_addr,
  input  logic [31:0]             req_data,
  input  logic [3:0]              req_byte_en,
  output logic                    rsp_valid,
  input  logic                    drain_busy,
  output logic [FINISH_ARG_W-1:0] finish_arg,
  output logic                    armed
);

  localparam logic [GRACE_W-1:0] c_grace = GRACE_CYCLES[GRACE_W-1:0];

  state_t                r_state;
  state_t                w_state_nxt;
  logic [EXITCODE_W-1:0] r_code;
  logic                  r_rsp_valid;
  logic                  w_accept;
  logic                  w_hit;
  logic                  w_capture;
  logic                  w_ctr_load;
  logic                  w_ctr_dec;
  logic                  w_at_one;
  logic                  w_unused;

  assign req_ready = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_accept  = req_valid && req_ready;

  // Only the low byte carries the code; the rest of the word is don't-care.
  assign w_hit     = (req_addr == EXIT_ADDR) && (req_addr[1:0] == 2'b00) && req_byte_en[0];
  assign w_capture = w_accept && w_hit && (r_state == ST_IDLE);
  assign w_unused  = ^{req_data[31:EXITCODE_W], req_byte_en[3:1]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ctr_load  = 1'b0;
    w_ctr_dec   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_capture) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!drain_busy) begin
          if (c_grace == '0) begin
            w_state_nxt = ST_FIRE;
          end else begin
            w_ctr_load  = 1'b1;
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (w_at_one) begin
          w_state_nxt = ST_FIRE;
        end else begin
          w_ctr_dec = 1'b1;
        end
      end
      ST_FIRE: begin
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_DONE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_code      <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= w_accept;
      if (w_capture) begin
        r_code <= req_data[EXITCODE_W-1:0];
      end
    end
  end

  ext_finish_grace_ctr u_grace_ctr (
    .CLK      (CLK),
    .RST      (RST),
    .load     (w_ctr_load),
    .load_val (c_grace),
    .dec      (w_ctr_dec),
    .at_one   (w_at_one)
  );

  assign rsp_valid  = r_rsp_valid;
  assign finish_arg = pack_finish(r_state == ST_FIRE, r_code);
  assign armed      = (r_state == ST_DRAIN) || (r_state == ST_WAIT) || (r_state == ST_FIRE);

endmodule

`default_nettype wire

// File: doc/ext_finish_req.md
Name: ext_finish_req

Overview:
- MMIO-side producer of the 9-bit {finish, exitcode} word that the simulation finish/exit monitor consumes.
- Sits on the core's data-memory store path.
- Accepts word stores to a dedicated exit address and latches the exit code.
- Waits until the console/putchar path has drained and a programmable grace interval has elapsed, then drives a single-cycle finish pulse carrying the code.

Parameters:
- EXIT_ADDR, 32'h4000_1000, byte address of the exit register; word-aligned.
- GRACE_CYCLES, 16, cycles to wait after drain before firing; 0 allowed; maximum 65535.

Ports:
- CLK  input  1  clock; all logic on posedge.
- RST  input  1  synchronous, active-high reset.
- req_valid  input  1  store request valid.
- req_ready  output  1  store request accepted this cycle when req_valid && req_ready.
- req_addr  input  32  store byte address.
- req_data  input  32  store data.
- req_byte_en  input  4  byte enables.
- rsp_valid  output  1  one-cycle acknowledge, the cycle after an accepted request.
- drain_busy  input  1  high while the console path still holds undelivered output.
- finish_arg  output  9  {finish, exitcode}; bit 8 = finish pulse, bits 7:0 = exit code.
- armed  output  1  high from exit-store acceptance until the end of FIRE.

Behaviour:
- States: IDLE, DRAIN, WAIT, FIRE, DONE; 3-bit encoding.
- Reset (synchronous, RST=1 at a posedge) forces:
  - state=IDLE, code_q=0, grace counter=0;
  - req_ready=1, rsp_valid=0, finish_arg=9'h000, armed=0.
- Reset mid-operation (any state) returns to IDLE the next edge; no finish pulse is emitted.
- Request decode:
  - An exit hit is req_addr == EXIT_ADDR with req_byte_en[0]=1.
  - The code is req_data[7:0]; bits 31:8 are ignored.
  - Non-hit stores are accepted and acknowledged but otherwise ignored.
  - Misaligned addresses never hit.
- req_ready:
  - High in IDLE and DONE.
  - Low in DRAIN, WAIT and FIRE, so no request is accepted there.
- rsp_valid is registered: it is high exactly the cycle after each accepted request.
- IDLE:
  - An accepted exit hit captures code_q and sets armed=1.
  - Next state is DRAIN.
- DRAIN:
  - Stays while drain_busy=1.
  - On drain_busy=0, loads the counter with GRACE_CYCLES and goes to WAIT; if GRACE_CYCLES=0, goes straight to FIRE.
  - drain_busy is sampled per cycle; a glitch back high in WAIT does not return to DRAIN.
- WAIT: decrements the counter each cycle; moves to FIRE when the counter reaches 1.
- FIRE:
  - finish_arg = {1'b1, code_q} for exactly one cycle; armed deasserts the next cycle.
  - Next state is DONE.
- DONE:
  - finish_arg = {1'b0, code_q}, held.
  - Further stores are accepted and acknowledged.
  - Exit hits are ignored: the first exit wins and there is no second pulse.
- Outside FIRE, finish_arg[8]=0. finish_arg[7:0] shows code_q in every state, and is 0 after reset until capture.
- Latency: exit-store acceptance at cycle t with drain_busy=0 produces the finish pulse at cycle t+2+GRACE_CYCLES.
  - GRACE_CYCLES=0 gives t+2.
- Simultaneous events:
  - An exit hit in the same cycle as RST: reset wins and the code is not captured.
  - drain_busy rising in the same cycle as acceptance: handled normally in DRAIN.
- Counter: 16-bit, no wrap; it only ever loads and decrements toward 1.

Decomposition:
- Package ext_finish_pkg holds:
  - the state enum;
  - the EXIT_ADDR default;
  - FINISH_ARG_W=9 and EXITCODE_W=8;
  - a helper function that packs {finish, code}.
- One sub-module, ext_finish_grace_ctr (load/decrement/at-one flag), is natural; everything else stays in the top.

Test Plan:
- Basic exit: store 32'h0000_0000 to EXIT_ADDR, drain_busy=0, GRACE=16 -> finish_arg=9'h100 single pulse at t+18; then DONE holding 9'h000.
- Fail code: store 32'hFFFF_FF2A, byte_en=4'b0001 -> pulse 9'h12A; bits 31:8 ignored; armed high from t+1 through the FIRE cycle.
- Drain hold: exit store while drain_busy=1 for 40 cycles -> no pulse and req_ready=0 throughout; pulse occurs GRACE+1 cycles after drain_busy falls.
- Decode misses: byte_en=4'b1110, address EXIT_ADDR+4, address EXIT_ADDR+1 -> each acknowledged via rsp_valid next cycle; state stays IDLE with no capture.
- Second exit in DONE: store code 5 after an earlier pulse with code 3 -> acknowledged; finish_arg stays 9'h003 and no new pulse.
- Reset mid-WAIT, plus GRACE_CYCLES=0 build:
  - Assert RST 5 cycles into WAIT -> finish_arg=0, state IDLE, no pulse.
  - With GRACE_CYCLES=0, exit store with drain_busy=0 -> pulse at t+2.
